uart_tx: RTL and testbench

UART transmitter with optional parity generation. It takes a parallel word from the system side and serialises it onto the UART line as start bit, data bits LSB first, optional parity bit, then stop bit. It sits on the TX side of the UART and is the transmit counterpart of the RX path's parity checker. Parity conventions match the receiver exactly, so one link configuration works end to end.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx_serializer.sv | 48 ++++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the TX path and the RX parity checker
//   uart_state_e    : 3-bit TX FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/PAR_ODD: parity type codes shared by TX and RX
//   parity_of()     : parity bit from a word's reduction XOR and the parity type
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even parity makes the total count of ones even, so it equals the XOR of
  // the data; odd parity is its complement.
  function automatic logic parity_of(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - system-side bundle of the UART transmitter
//   P_DATA     : word to transmit
//   Data_Valid : transmit request
//   PAR_EN     : insert parity bit
//   PAR_TYP    : 0 even, 1 odd
//   TX_OUT     : serial line, idles high
//   Busy       : frame on the line
//   master     : system side, slave : uart_tx
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - data latch, shift register and bit counter of the UART transmitter
//   CLK, RST : clock, synchronous active-low reset
//   load     : latch data_in, clear counter
//   shift    : a data bit is being launched this edge, expose the next one
//   advance  : move the bit counter to the next data bit
//   data_in  : word to latch
//   word     : latched word (parity source)
//   bit_out  : data bit to launch on the next shift
//   last_bit : the bit currently on the line is the final data bit
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  bit_out,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      word  <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      word  <= data_in;
      shreg <= data_in;
      cnt   <= '0;
    end else begin
      if (shift)   shreg <= shreg >> 1;
      if (advance) cnt   <= cnt + 1'b1;
    end
  end

  // bit_out is consumed on the same edge that shifts it away.
  assign bit_out  = shreg[0];
  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, data LSB first, optional parity, stop bit
//   CLK : bit clock, one UART bit per cycle
//   RST : synchronous active-low reset
//   bus : uart_tx_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in; TX_OUT, Busy out)
//   UART_TX_PARITY_EN : when defined, builds the PARITY state and parity logic
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  uart_state_e           state, next_state;
  logic                  tx_next, busy_next;
  logic                  load, shift, advance;
  logic                  bit_out, last_bit;
  logic [DATA_WIDTH-1:0] word_q;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift    (shift),
    .advance  (advance),
    .data_in  (bus.P_DATA),
    .word     (word_q),
    .bit_out  (bit_out),
    .last_bit (last_bit)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_typ_q, par_bit;

  // Parity options are frozen with the word so mid-frame changes are harmless.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (load) begin
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
    end
  end

  assign par_bit = parity_of(^word_q, par_typ_q);
`else
  logic unused_par_cfg;
  assign unused_par_cfg = ^{bus.PAR_EN, bus.PAR_TYP, word_q};
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      bus.TX_OUT <= 1'b1;
      bus.Busy   <= 1'b0;
    end else begin
      state      <= next_state;
      bus.TX_OUT <= tx_next;
      bus.Busy   <= busy_next;
    end
  end

  // Outputs are registered, so tx_next/busy_next describe the state being
  // entered, not the current one.
  always_comb begin
    next_state = state;
    tx_next    = 1'b1;
    busy_next  = 1'b1;
    load       = 1'b0;
    shift      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.Data_Valid) begin
          load       = 1'b1;
          next_state = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        next_state = DATA;
        shift      = 1'b1;
        tx_next    = bit_out;
      end
      DATA: begin
        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            next_state = PARITY;
            tx_next    = par_bit;
          end else begin
            next_state = STOP;
          end
`else
          next_state = STOP;
`endif
        end else begin
          shift   = 1'b1;
          advance = 1'b1;
          tx_next = bit_out;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: next_state = STOP;
`endif
      STOP: begin
        next_state = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        next_state = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (DATA_WIDTH=8), honours UART_TX_PARITY_EN
module tb_uart_tx;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, act, exp);
    end
  endtask

  function automatic int frame_len(input logic pe);
    return (pe && PAR_BUILT) ? 11 : 10;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input logic pe,
                                   input logic ep, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (j == 9 && pe && PAR_BUILT) return ep;
    return 1'b1;
  endfunction

  // Called #1 after the edge that put bit from_j on the line.
  task automatic frame_body(input logic [7:0] d, input logic pe, input logic ep,
                            input int from_j, input bit scramble, input string tag);
    int len;
    len = frame_len(pe);
    for (int j = from_j; j < len; j++) begin
      check($sformatf("%s_tx%0d", tag, j), bus.TX_OUT, exp_bit(d, pe, ep, j));
      check($sformatf("%s_busy%0d", tag, j), bus.Busy, 1'b1);
      @(negedge CLK);
      if (scramble) begin
        bus.P_DATA  = 8'h00;
        bus.PAR_EN  = ~pe;
        bus.PAR_TYP = ~bus.PAR_TYP;
      end
      bus.Data_Valid = scramble && (j == 3 || j == len - 1);
      @(posedge CLK); #1;
    end
    check($sformatf("%s_idle_tx", tag), bus.TX_OUT, 1'b1);
    check($sformatf("%s_idle_busy", tag), bus.Busy, 1'b0);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    @(posedge CLK); #1;
    check($sformatf("%s_idle2_tx", tag), bus.TX_OUT, 1'b1);
    check($sformatf("%s_idle2_busy", tag), bus.Busy, 1'b0);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    // Parity values worked by hand: count of ones even -> even parity 0.
    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_par: 1'b0};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, exp_par: 1'b0};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, exp_par: 1'b1};
    vecs[3] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, exp_par: 1'b1};
    vecs[4] = '{data: 8'hFF, pe: 1'b1, pt: 1'b1, exp_par: 1'b1};
    vecs[5] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, exp_par: 1'b1};
    vecs[6] = '{data: 8'h3C, pe: 1'b1, pt: 1'b0, exp_par: 1'b0};

    RST            = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_tx", bus.TX_OUT, 1'b1);
    check("reset_busy", bus.Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_tx", bus.TX_OUT, 1'b1);
    check("post_reset_busy", bus.Busy, 1'b0);

    // Table: inputs are scrambled and Data_Valid pulsed while busy.
    for (int v = 0; v < 7; v++) begin
      start_frame(vecs[v].data, vecs[v].pe, vecs[v].pt);
      frame_body(vecs[v].data, vecs[v].pe, vecs[v].exp_par, 0, 1'b1,
                 $sformatf("vec%0d", v));
    end

    // Data_Valid held high across two frames: exactly one idle cycle between.
    start_frame(8'h3C, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("b2b_a_tx%0d", j), bus.TX_OUT, exp_bit(8'h3C, 1'b0, 1'b0, j));
      check($sformatf("b2b_a_busy%0d", j), bus.Busy, 1'b1);
      @(negedge CLK);
      bus.P_DATA = 8'hC3;
      @(posedge CLK); #1;
    end
    check("b2b_gap_tx", bus.TX_OUT, 1'b1);
    check("b2b_gap_busy", bus.Busy, 1'b0);
    @(posedge CLK); #1;
    check("b2b_b_start_tx", bus.TX_OUT, 1'b0);
    check("b2b_b_start_busy", bus.Busy, 1'b1);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    @(posedge CLK); #1;
    frame_body(8'hC3, 1'b0, 1'b0, 1, 1'b0, "b2b_b");

    // Reset during data bit 3, with Data_Valid already high at release.
    start_frame(8'hA5, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rst_pre_tx%0d", j), bus.TX_OUT, exp_bit(8'hA5, 1'b0, 1'b0, j));
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
      if (j < 4) begin
        @(posedge CLK); #1;
      end
    end
    RST            = 1'b0;
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = 8'h5A;
    @(posedge CLK); #1;
    check("rst_mid_tx", bus.TX_OUT, 1'b1);
    check("rst_mid_busy", bus.Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_release_start_tx", bus.TX_OUT, 1'b0);
    check("rst_release_busy", bus.Busy, 1'b1);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    @(posedge CLK); #1;
    frame_body(8'h5A, 1'b0, 1'b0, 1, 1'b0, "rst_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
